cdb_arbiter: RTL and testbench

Round-robin arbiter for the common data bus (CDB) of the Tomasulo core. It shares the single result broadcast path between the ADD/SUB reservation-station group, the MUL/DIV group and the load/store buffer. Each cycle it grants at most one requester and registers that requester's ROB tag and result onto the CDB. It also produces a one-hot completion vector for the eight reorder-buffer entries. The block sits between the functional-unit result stages and the ROB / reservation-station tag-match logic.

---
 rtl/cdb_arbiter_pkg.sv | 16 +
 rtl/cdb_arbiter_pick.sv | 30 +++
 rtl/cdb_arbiter.sv | 84 ++++++++
 tb/tb_cdb_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared core constants for the CDB arbiter.
// Requester ids, ROB sizing and the garbage RS index.
package cdb_arbiter_pkg;

  localparam int ROB_ENTRIES = 8;
  localparam int TAG_W       = 3;
  localparam int SRC_W       = 2;
  localparam int GARBAGE_RS  = 12;

  typedef enum logic [SRC_W-1:0] {
    REQ_ADD = 2'd0,
    REQ_MUL = 2'd1,
    REQ_LD  = 2'd2
  } req_id_e;

endpackage

// File: rtl/cdb_arbiter_pick.sv
// Rotating-priority picker: first req at or after ptr wins.
// Pure combinational; returns one-hot gnt, index and any.
module rr_pick #(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   ptr,
  output logic [N-1:0] gnt,
  output logic [1:0]   idx,
  output logic         any
);

  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = 2'(j);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: ADD/SUB, MUL/DIV and LOAD share one
// registered broadcast; also decodes the ROB completion vector.
module cdb_arbiter #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 3,
  parameter int N_REQ  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    cdb_hold,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*TAG_W-1:0]  req_tag,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        gnt,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [DATA_W-1:0]       cdb_data,
  output logic [1:0]              cdb_src,
  output logic [2**TAG_W-1:0]     rob_done
);
  import cdb_arbiter_pkg::*;

  logic [SRC_W-1:0] ptr;
  logic [SRC_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_gnt;
  logic             pick_any;
  logic             ok;
  logic             fire;
  logic [TAG_W-1:0]  sel_tag;
  logic [DATA_W-1:0] sel_data;

  rr_pick #(.N(N_REQ)) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // rst_n gates gnt so no grant is visible while in reset
  assign ok   = rst_n && start && !cdb_hold;
  assign fire = ok && pick_any;
  assign gnt  = ok ? pick_gnt : '0;

  always_comb begin
    sel_tag  = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_gnt[i]) begin
        sel_tag  = req_tag[i*TAG_W +: TAG_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end else if (!start) begin
      ptr       <= '0;
      cdb_valid <= 1'b0;
    end else if (fire) begin
      ptr       <= (pick_idx == SRC_W'(N_REQ-1)) ?
                   '0 : pick_idx + 1'b1;
      cdb_valid <= 1'b1;
      cdb_tag   <= sel_tag;
      cdb_data  <= sel_data;
      cdb_src   <= pick_idx;
    end else begin
      cdb_valid <= 1'b0;
    end
  end

  always_comb begin
    rob_done          = '0;
    rob_done[cdb_tag] = cdb_valid;
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed scoreboard bench for cdb_arbiter.
// Expected broadcasts are queued at grant time, popped a cycle later.
module tb_cdb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        cdb_hold;
  logic [2:0]  req;
  logic [8:0]  req_tag;
  logic [95:0] req_data;
  logic [2:0]  gnt;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [1:0]  cdb_src;
  logic [7:0]  rob_done;

  typedef struct {
    logic        v;
    logic [2:0]  tag;
    logic [31:0] data;
    logic [1:0]  src;
  } exp_t;

  exp_t q[$];
  exp_t last;
  logic [2:0]  tags [3];
  logic [31:0] datas [3];
  int checks = 0;
  int errors = 0;

  cdb_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .cdb_hold (cdb_hold),
    .req      (req),
    .req_tag  (req_tag),
    .req_data (req_data),
    .gnt      (gnt),
    .cdb_valid(cdb_valid),
    .cdb_tag  (cdb_tag),
    .cdb_data (cdb_data),
    .cdb_src  (cdb_src),
    .rob_done (rob_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_inputs();
    req_tag  = {tags[2], tags[1], tags[0]};
    req_data = {datas[2], datas[1], datas[0]};
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_valid"}, 64'(cdb_valid), 64'h0);
    chk({tag, "_tag"},   64'(cdb_tag),   64'h0);
    chk({tag, "_data"},  64'(cdb_data),  64'h0);
    chk({tag, "_src"},   64'(cdb_src),   64'h0);
    chk({tag, "_done"},  64'(rob_done),  64'h0);
    chk({tag, "_gnt"},   64'(gnt),       64'h0);
  endtask

  // Called at a negedge; returns at the following negedge
  task automatic cycle(input string tag,
                       input logic s,
                       input logic h,
                       input logic [2:0] r,
                       input logic [2:0] eg);
    exp_t e;
    exp_t o;
    int   k;
    start    = s;
    cdb_hold = h;
    req      = r;
    load_inputs();
    #1;
    chk({tag, "_gnt"}, 64'(gnt), 64'(eg));
    e = last;
    e.v = 1'b0;
    k = -1;
    for (int i = 0; i < 3; i++)
      if (eg[i]) k = i;
    if (k >= 0) begin
      e.v    = 1'b1;
      e.tag  = tags[k];
      e.data = datas[k];
      e.src  = 2'(k);
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    o = q.pop_front();
    last = o;
    chk({tag, "_valid"}, 64'(cdb_valid), 64'(o.v));
    chk({tag, "_tag"},   64'(cdb_tag),   64'(o.tag));
    chk({tag, "_data"},  64'(cdb_data),  64'(o.data));
    chk({tag, "_src"},   64'(cdb_src),   64'(o.src));
    chk({tag, "_done"},  64'(rob_done),
        o.v ? (64'h1 << o.tag) : 64'h0);
    @(negedge clk);
  endtask

  initial begin
    tags[0] = 3'd1; tags[1] = 3'd2; tags[2] = 3'd3;
    datas[0] = 32'hA; datas[1] = 32'hB; datas[2] = 32'hC;
    last = '{v: 1'b0, tag: 3'd0, data: 32'd0, src: 2'd0};
    rst_n = 1'b0;
    start = 1'b1;
    cdb_hold = 1'b0;
    req = 3'b111;
    load_inputs();
    #1;
    chk_cleared("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    cycle("idle0", 1, 0, 3'b000, 3'b000);
    cycle("idle1", 1, 0, 3'b000, 3'b000);

    cycle("rr0", 1, 0, 3'b111, 3'b001);
    cycle("rr1", 1, 0, 3'b111, 3'b010);
    cycle("rr2", 1, 0, 3'b111, 3'b100);
    cycle("rr3", 1, 0, 3'b111, 3'b001);

    cycle("mul", 1, 0, 3'b010, 3'b010);
    cycle("p2a", 1, 0, 3'b101, 3'b100);
    cycle("p2b", 1, 0, 3'b001, 3'b001);
    cycle("p1",  1, 0, 3'b111, 3'b010);
    cycle("none", 1, 0, 3'b000, 3'b000);

    cycle("hold0", 1, 1, 3'b010, 3'b000);
    cycle("hold1", 1, 1, 3'b010, 3'b000);
    cycle("hold2", 1, 1, 3'b010, 3'b000);
    cycle("hold3", 1, 0, 3'b010, 3'b010);

    tags[0] = 3'd5;
    datas[0] = 32'hDEAD_0005;
    cycle("t5",    1, 0, 3'b001, 3'b001);
    cycle("flush", 0, 1, 3'b111, 3'b000);
    cycle("rest",  1, 0, 3'b111, 3'b001);
    cycle("pre",   1, 0, 3'b111, 3'b010);

    #2;
    rst_n = 1'b0;
    #1;
    chk_cleared("arst");
    @(posedge clk);
    #1;
    chk_cleared("arst_edge");
    @(negedge clk);
    rst_n = 1'b1;
    last = '{v: 1'b0, tag: 3'd0, data: 32'd0, src: 2'd0};
    cycle("post0", 1, 0, 3'b111, 3'b001);
    cycle("post1", 1, 0, 3'b110, 3'b010);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
